seg7_display_driver: RTL and testbench

//  Consumer of the processor's 16-bit display_output bus; drives a 4-digit multiplexed
//  7-segment display in hex. Accepts values through a valid/ready handshake.

---
 rtl/seg7_display_driver.sv | 144 ++++++++++++++
 tb/tb_seg7_display_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_driver.sv
// Four-digit multiplexed hex 7-segment driver with a valid/ready input.
// New values are latched into a pending slot and only shown at a frame boundary.
module seg7_display_driver #(
    parameter int REFRESH_DIV        = 100000,
    parameter bit LEADING_ZERO_BLANK = 1'b1,
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit AN_ACTIVE_LOW      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] shown_value
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] AN_POL  = {4{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SHOW,
        ST_SHOW_PEND
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] scan_count_reg;
    logic [1:0]       digit_idx_reg;
    logic [15:0]      shown_value_reg;
    logic [15:0]      pending_reg;
    logic             pending_valid_reg;
    logic [6:0]       seg_reg;
    logic [3:0]       an_reg;

    logic        scan_tick;
    logic        frame_boundary;
    logic        accept;
    logic        lit;
    logic        digit_on;
    logic [3:0]  nibble;
    logic [6:0]  hex_seg;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic [3:0]  an_onehot;
    logic [3:0]  nibbles [4];
    logic [3:0]  digit_nz;

    assign scan_tick      = clk_enable && (scan_count_reg == CNT_LAST);
    assign frame_boundary = scan_tick && (digit_idx_reg == 2'd3);
    assign accept         = data_valid && !pending_valid_reg;
    assign lit            = (state_reg != ST_BLANK);

    assign data_ready  = ~pending_valid_reg;
    assign shown_value = shown_value_reg;
    assign seg         = seg_reg;
    assign an          = an_reg;

    // digit_nz[k] is set when any nibble from k upward is non-zero
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nibbles[gi]  = shown_value_reg[4*gi +: 4];
            assign digit_nz[gi] = |shown_value_reg[15:4*gi];
        end
    endgenerate

    assign nibble    = nibbles[digit_idx_reg];
    assign an_onehot = 4'b0001 << digit_idx_reg;
    assign digit_on  = lit && !blank &&
                       ((digit_idx_reg == 2'd0) || !LEADING_ZERO_BLANK || digit_nz[digit_idx_reg]);

    always_comb begin
        hex_seg = 7'h00;
        case (nibble)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            4'hF: hex_seg = 7'h71;
            default: hex_seg = 7'h00;
        endcase
    end

    assign seg_next = digit_on ? hex_seg : 7'h00;
    assign an_next  = digit_on ? an_onehot : 4'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_BLANK;
            scan_count_reg    <= '0;
            digit_idx_reg     <= 2'd0;
            shown_value_reg   <= 16'h0000;
            pending_reg       <= 16'h0000;
            pending_valid_reg <= 1'b0;
            seg_reg           <= SEG_POL;
            an_reg            <= AN_POL;
        end else begin
            if (clk_enable) begin
                if (scan_count_reg == CNT_LAST) begin
                    scan_count_reg <= '0;
                    digit_idx_reg  <= digit_idx_reg + 2'd1;
                end else begin
                    scan_count_reg <= scan_count_reg + 1'b1;
                end
            end

            // A value accepted on the boundary edge itself waits for the next frame
            if (frame_boundary && pending_valid_reg) begin
                shown_value_reg   <= pending_reg;
                pending_valid_reg <= 1'b0;
            end else if (accept) begin
                pending_reg       <= data_in;
                pending_valid_reg <= 1'b1;
            end

            case (state_reg)
                ST_BLANK:     if (frame_boundary && pending_valid_reg) state_reg <= ST_SHOW;
                ST_SHOW:      if (accept) state_reg <= ST_SHOW_PEND;
                ST_SHOW_PEND: if (frame_boundary) state_reg <= ST_SHOW;
                default:      state_reg <= ST_BLANK;
            endcase

            seg_reg <= seg_next ^ SEG_POL;
            an_reg  <= an_next ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Scoreboarded bench for seg7_display_driver with REFRESH_DIV=4 (16 enabled clocks per frame).
// A behavioural model tracks scan position and pending state from the driven stimulus.
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_valid = 1'b0;
    logic        blank = 1'b0;
    logic        data_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] shown_value;

    seg7_display_driver #(
        .REFRESH_DIV        (4),
        .LEADING_ZERO_BLANK (1'b1),
        .SEG_ACTIVE_LOW     (1'b1),
        .AN_ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .blank       (blank),
        .seg         (seg),
        .an          (an),
        .shown_value (shown_value)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0] value;
        int          target;
    } sb_item_t;

    sb_item_t    sb_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          en_cnt = 0;
    int          acc_count = 0;
    int          cycle = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_pend_val = 16'h0000;
    logic [15:0] m_shown = 16'h0000;
    logic        m_lit = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Expected registered outputs, computed from model state before the edge
    task automatic model_out(output logic [3:0] e_an, output logic [6:0] e_seg);
        int idx;
        logic [3:0] nib;
        idx = (en_cnt / 4) % 4;
        nib = 4'((m_shown >> (4 * idx)) & 16'hF);
        e_an  = 4'hF;
        e_seg = 7'h7F;
        if (m_lit && !blank && (idx == 0 || (m_shown >> (4 * idx)) != 16'h0)) begin
            e_an  = ~(4'b0001 << idx);
            e_seg = ~HEX[nib];
        end
    endtask

    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       r_edge;
        logic       en_edge;
        logic       boundary;
        sb_item_t   item;
        r_edge  = reset;
        en_edge = clk_enable;
        if (r_edge) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
        end else begin
            model_out(e_an, e_seg);
        end
        @(posedge clk);
        cycle++;
        if (r_edge) begin
            en_cnt = 0;
            m_pend = 1'b0;
            m_shown = 16'h0000;
            m_lit = 1'b0;
            sb_q.delete();
        end else begin
            boundary = en_edge && (en_cnt % 16 == 15);
            if (boundary && m_pend) begin
                m_shown = m_pend_val;
                m_pend = 1'b0;
                m_lit = 1'b1;
            end else if (data_valid && !m_pend) begin
                m_pend = 1'b1;
                m_pend_val = data_in;
                item.value = data_in;
                item.target = en_edge ? 16 * ((en_cnt + 1) / 16 + 1) : 16 * (en_cnt / 16 + 1);
                sb_q.push_back(item);
                acc_count++;
                $display("accept value=%h cycle=%0d show_at_count=%0d", data_in, cycle, item.target);
            end
            if (en_edge) en_cnt++;
        end
        #1;
        check_value("an", an, e_an);
        check_value("seg", seg, e_seg);
        check_value("ready", data_ready, !m_pend);
        if (!r_edge && en_edge && sb_q.size() > 0 && en_cnt == sb_q[0].target) begin
            item = sb_q.pop_front();
            check_value("sb_shown", shown_value, item.value);
            $display("shown value=%h cycle=%0d", shown_value, cycle);
        end
    endtask

    task automatic run_to(input int phase);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((en_cnt % 16) != phase && n < 200);
        if ((en_cnt % 16) != phase) check_value("run_to_timeout", en_cnt % 16, phase);
    endtask

    task automatic send(input logic [15:0] v);
        int start;
        int n;
        start = acc_count;
        n = 0;
        data_valid = 1'b1;
        data_in = v;
        while (acc_count == start && n < 200) begin
            tick();
            n++;
        end
        data_valid = 1'b0;
        if (acc_count == start) check_value("send_timeout", acc_count, start + 1);
    endtask

    logic [3:0] an_12ab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_12ab [4] = '{7'h03, 7'h08, 7'h24, 7'h79};

    initial begin
        // Reset, then three idle frames with nothing lit
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (48) tick();
        check_value("t1_shown", shown_value, 16'h0000);
        check_value("t1_an", an, 4'hF);

        // Load 12AB and walk through the four digits
        send(16'h12AB);
        check_value("t2_ready_busy", data_ready, 1'b0);
        run_to(0);
        check_value("t2_ready_free", data_ready, 1'b1);
        check_value("t2_shown", shown_value, 16'h12AB);
        for (int k = 0; k < 4; k++) begin
            run_to(4 * k + 2);
            check_value("t2_an", an, an_12ab[k]);
            check_value("t2_seg", seg, seg_12ab[k]);
        end

        // Leading-zero blanking
        send(16'h0005);
        run_to(0);
        run_to(2);
        check_value("t3_an_d0", an, 4'b1110);
        check_value("t3_seg_d0", seg, 7'h12);
        run_to(6);
        check_value("t3_an_d1", an, 4'b1111);
        send(16'h0000);
        run_to(0);
        run_to(2);
        check_value("t3_zero_seg", seg, 7'h40);
        check_value("t3_zero_an", an, 4'b1110);
        for (int k = 1; k < 4; k++) begin
            run_to(4 * k + 2);
            check_value("t3_zero_hi", an, 4'b1111);
        end

        // Held valid while busy is taken after the boundary; a short pulse is lost
        send(16'h00C1);
        send(16'h00C0);
        check_value("t4_busy", data_ready, 1'b0);
        data_valid = 1'b1;
        data_in = 16'hDEAD;
        tick();
        data_valid = 1'b0;
        run_to(0);
        check_value("t4_shown", shown_value, 16'h00C0);
        run_to(0);
        check_value("t4_pulse_lost", shown_value, 16'h00C0);

        // Scan freeze and global blank
        run_to(5);
        clk_enable = 1'b0;
        repeat (20) tick();
        clk_enable = 1'b1;
        repeat (7) tick();
        blank = 1'b1;
        tick();
        check_value("t5_blank_an", an, 4'hF);
        repeat (6) tick();
        blank = 1'b0;
        repeat (20) tick();

        // Reset while a value is pending
        send(16'h4321);
        check_value("t6_pending", data_ready, 1'b0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_value("t6_shown", shown_value, 16'h0000);
        check_value("t6_an", an, 4'hF);
        check_value("t6_seg", seg, 7'h7F);
        check_value("t6_ready", data_ready, 1'b1);
        repeat (40) tick();
        check_value("t6_still_blank", shown_value, 16'h0000);

        check_value("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
